// File: rtl/master.sv
// master: stream burst source. Emits bursts of trans_lenth beats over a
// valid/ready handshake, with m_tlast on the final beat. All outputs are
// registered.
// By default each beat carries its beat index truncated to data_width.
// Define MASTER_LFSR_PATTERN_EN to carry an LFSR sequence instead. The LFSR
// is seeded with 1 at the start of each burst. Burst length, tlast and
// handshake timing are the same in both builds.
module master #(
    parameter int data_width  = 4,
    parameter int trans_width = 8,
    parameter int trans_lenth = 2**trans_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_tlast
);

    typedef enum logic {IDLE, SEND} state_t;

    // Counter value that marks the final beat of a burst.
    localparam logic [trans_width-1:0] LAST_BEAT = trans_width'(trans_lenth - 1);

    state_t                 state, state_nxt;
    logic [trans_width-1:0] cnt, cnt_nxt;
    logic [data_width-1:0]  data_nxt;
    logic                   valid_nxt, tlast_nxt;
    logic                   xfer;

    assign xfer = m_valid & m_ready;

`ifdef MASTER_LFSR_PATTERN_EN
    logic [data_width-1:0] lfsr, lfsr_nxt, lfsr_step;
    // lfsr holds the payload currently on the bus.
    // lfsr_step is the payload of the following beat.
    assign lfsr_step = {lfsr[data_width-2:0], lfsr[data_width-1] ^ lfsr[data_width-2]};
`endif

    // Next-state and next-output decode. Every output register is loaded
    // from here, so the outputs change only on a clock edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = m_data;
        valid_nxt = m_valid;
        tlast_nxt = m_tlast;
`ifdef MASTER_LFSR_PATTERN_EN
        lfsr_nxt  = lfsr;
`endif
        case (state)
            IDLE: begin
                // m_ready is ignored here because m_valid is low.
                if (en) begin
                    state_nxt = SEND;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                    tlast_nxt = (LAST_BEAT == '0);
`ifdef MASTER_LFSR_PATTERN_EN
                    data_nxt  = data_width'(1);
                    lfsr_nxt  = data_width'(1);
`else
                    data_nxt  = '0;
`endif
                end
            end
            SEND: begin
                // en is ignored here. The outputs hold until a transfer.
                if (xfer) begin
                    if (m_tlast) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        valid_nxt = 1'b0;
                        tlast_nxt = 1'b0;
                        data_nxt  = '0;
`ifdef MASTER_LFSR_PATTERN_EN
                        lfsr_nxt  = data_width'(1);
`endif
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        valid_nxt = 1'b1;
                        tlast_nxt = (cnt_nxt == LAST_BEAT);
`ifdef MASTER_LFSR_PATTERN_EN
                        data_nxt  = lfsr_step;
                        lfsr_nxt  = lfsr_step;
`else
                        data_nxt  = data_width'(cnt_nxt);
`endif
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    // Reset takes priority over en and m_ready.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Output and beat-counter registers. Reset takes priority, so the
    // outputs are defined from the first reset edge even when en is X.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_tlast <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            m_data  <= data_nxt;
            m_valid <= valid_nxt;
            m_tlast <= tlast_nxt;
        end
    end

`ifdef MASTER_LFSR_PATTERN_EN
    // LFSR payload register. It rests at the seed value between bursts.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= data_width'(1);
        else     lfsr <= lfsr_nxt;
    end
`endif

endmodule

// File: tb/tb_master.sv
// tb_master: scoreboard bench for master with default parameters.
// At each burst start the bench pushes every expected beat (data, last).
// Each beat is popped and compared on the cycle it transfers.
module tb_master;
    localparam int DW = 4;
    localparam int TW = 8;
    localparam int TL = 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst, en, m_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_tlast;

    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];

    // Reference LFSR sequence for a 4-bit payload. It repeats every 15 beats.
    logic [DW-1:0] lfsr_seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                     4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};

    master #(.data_width(DW), .trans_width(TW), .trans_lenth(TL)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_tlast (m_tlast)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected beats of one burst onto the scoreboard.
    task automatic push_burst();
        beat_t b;
        for (int i = 0; i < TL; i++) begin
`ifdef MASTER_LFSR_PATTERN_EN
            b.data = lfsr_seq[i % 15];
`else
            b.data = DW'(i % 16);
`endif
            b.last = (i == TL - 1);
            sb.push_back(b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'bx; m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (m_valid !== 1'b0 || m_tlast !== 1'b0 || m_data !== '0) begin
                failures++;
                $display("FAIL reset cyc%0d: valid=%b tlast=%b data=%h, need 0/0/0", i, m_valid, m_tlast, m_data);
            end
        end
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_ready_idle();
        m_ready = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b0 || m_tlast !== 1'b0 || m_data !== '0) begin
                failures++;
                $display("FAIL ready_idle cyc%0d: valid=%b tlast=%b data=%h, need 0/0/0", i, m_valid, m_tlast, m_data);
            end
        end
    endtask

    task automatic test_stall();
        sb.delete();
        push_burst();
        m_ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_tlast !== 1'b0 || m_data !== sb[0].data) begin
                failures++;
                $display("FAIL stall cyc%0d: valid=%b tlast=%b data=%h, need 1/0/%h", i, m_valid, m_tlast, m_data, sb[0].data);
            end
        end
        en = 1'b0;
        // Abort the stalled burst so that the next test starts from reset.
        rst = 1'b1; tick(); rst = 1'b0;
        sb.delete();
    endtask

    // mode 0: m_ready held high. mode 1: m_ready toggles mid-burst, then is random.
    task automatic test_burst(input int mode, input string name);
        int beats = 0;
        int cyc   = 0;
        beat_t e;
        push_burst();
        en = 1'b1; m_ready = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s start: valid=%b, need 1", name, m_valid);
        end
        while (beats < TL && cyc < 4000) begin
            if (mode == 0)                      m_ready = 1'b1;
            else if (cyc >= 40 && cyc < 48)     m_ready = cyc[0];
            else if (cyc >= 48)                 m_ready = 1'($urandom_range(0, 1));
            else                                m_ready = 1'b1;
            #0;
            if (m_valid && m_ready) begin
                e = sb.pop_front();
                checks++;
                if (m_data !== e.data || m_tlast !== e.last) begin
                    failures++;
                    $display("FAIL %s beat%0d: data=%h tlast=%b, need %h/%b", name, beats, m_data, m_tlast, e.data, e.last);
                end
                beats++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (beats != TL) begin
            failures++;
            $display("FAIL %s count: beats=%0d, need %0d", name, beats, TL);
        end
        if (mode == 0) begin
            checks++;
            if (cyc != TL) begin
                failures++;
                $display("FAIL %s consecutive: cycles=%0d, need %0d", name, cyc, TL);
            end
        end
        checks++;
        if (m_valid !== 1'b0 || m_tlast !== 1'b0 || m_data !== '0) begin
            failures++;
            $display("FAIL %s end: valid=%b tlast=%b data=%h, need 0/0/0", name, m_valid, m_tlast, m_data);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_abort();
        int beats = 0;
        int cyc   = 0;
        beat_t e;
        logic [DW-1:0] first;
        sb.delete();
        push_burst();
        first = sb[0].data;
        en = 1'b1; m_ready = 1'b1;
        tick();
        en = 1'b0;
        while (beats < 100 && cyc < 400) begin
            e = sb.pop_front();
            checks++;
            if (m_valid !== 1'b1 || m_data !== e.data || m_tlast !== e.last) begin
                failures++;
                $display("FAIL abort pre beat%0d: valid=%b data=%h tlast=%b, need 1/%h/%b", beats, m_valid, m_data, m_tlast, e.data, e.last);
            end
            beats++;
            tick();
            cyc++;
        end
        // Beat 100 is on the bus now. Reset it away.
        rst = 1'b1; tick(); rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b0 || m_tlast !== 1'b0 || m_data !== '0) begin
                failures++;
                $display("FAIL abort post cyc%0d: valid=%b tlast=%b data=%h, need 0/0/0", i, m_valid, m_tlast, m_data);
            end
            tick();
        end
        en = 1'b1; m_ready = 1'b0;
        tick();
        en = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== first) begin
            failures++;
            $display("FAIL abort restart: valid=%b data=%h, need 1/%h", m_valid, m_data, first);
        end
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int beats = 0;
        int cyc   = 0;
        int idle  = 0;
        beat_t e;
        sb.delete();
        push_burst();
        push_burst();
        en = 1'b1; m_ready = 1'b1;
        tick();
        while (beats < 2 * TL && cyc < 2000) begin
            if (m_valid) begin
                e = sb.pop_front();
                checks++;
                if (m_data !== e.data || m_tlast !== e.last) begin
                    failures++;
                    $display("FAIL b2b beat%0d: data=%h tlast=%b, need %h/%b", beats, m_data, m_tlast, e.data, e.last);
                end
                beats++;
            end else begin
                idle++;
                checks++;
                if (m_data !== '0 || m_tlast !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b idle: data=%h tlast=%b, need 0/0", m_data, m_tlast);
                end
            end
            tick();
            cyc++;
        end
        checks++;
        if (beats != 2 * TL || idle != 1) begin
            failures++;
            $display("FAIL b2b gap: beats=%0d idle=%0d, need %0d/1", beats, idle, 2 * TL);
        end
        en = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ready_idle();
        test_stall();
        test_burst(0, "full");
        test_burst(1, "backpressure");
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
